// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: way count, entry layout,
// and PC-to-index/tag split for a configurable set-index width.
package btb_pkg;

    localparam int BTB_WAYS = 2;

    // Tag field is sized for the narrowest index (30 bits); unused upper bits stay zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
    } btb_entry_t;

    function automatic logic [31:0] btb_index(input logic [31:0] pc, input int unsigned index_bits);
        return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [29:0] btb_tag(input logic [31:0] pc, input int unsigned index_bits);
        logic [31:0] shifted;
        shifted = pc >> (index_bits + 2);
        return shifted[29:0];
    endfunction

endpackage

// File: rtl/btb_set_victim.sv
// Per-set way selection: which way hits (way 0 wins a double match) and which way
// a new entry should be allocated into (first invalid way, else the LRU way).
module btb_set_victim
    import btb_pkg::*;
(
    input  logic [BTB_WAYS-1:0] valid,
    input  logic [BTB_WAYS-1:0] tag_eq,
    input  logic                lru,
    output logic                hit,
    output logic                hit_way,
    output logic                alloc_way
);

    logic [BTB_WAYS-1:0] way_hit;

    assign way_hit = valid & tag_eq;

    always_comb begin
        hit     = |way_hit;
        hit_way = 1'b0;
        if (!way_hit[0] && way_hit[1]) begin
            hit_way = 1'b1;
        end
    end

    always_comb begin
        if (!valid[0]) begin
            alloc_way = 1'b0;
        end else if (!valid[1]) begin
            alloc_way = 1'b1;
        end else begin
            alloc_way = lru;
        end
    end

endmodule

// File: rtl/btb_next_pc.sv
// Fetch-stage BTB (2-way set-associative) and next-PC predictor, trained from mem stage.
// Optional lookup/hit counters are built when BTB_STATS_EN is defined.
module btb_next_pc
    import btb_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    input  logic        lookup_en,
    input  logic        predicted,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken,
`ifdef BTB_STATS_EN
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits,
`endif
    output logic        btb_hit,
    output logic [31:0] btb_target,
    output logic [31:0] pred_next_pc
);

    localparam int SETS     = 2 ** INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic                valid_q [SETS][BTB_WAYS];
    logic                lru_q   [SETS];
    logic [TAG_BITS-1:0] tag_mem [SETS][BTB_WAYS];
    logic [31:0]         tgt_mem [SETS][BTB_WAYS];

    logic [31:0] fetch_pc_q;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [29:0]           lk_tag;
    btb_entry_t            lk_entry [BTB_WAYS];
    logic                  lk_hit;
    logic [31:0]           lk_target;

    logic [INDEX_BITS-1:0] up_idx;
    logic [29:0]           up_tag;
    btb_entry_t            up_entry [BTB_WAYS];
    logic [BTB_WAYS-1:0]   up_valid;
    logic [BTB_WAYS-1:0]   up_tag_eq;
    logic                  up_hit;
    logic                  up_hit_way;
    logic                  up_alloc_way;
    logic                  up_alloc;
    logic                  up_way;

    assign lk_idx = INDEX_BITS'(btb_index(fetch_pc, INDEX_BITS));
    assign lk_tag = btb_tag(fetch_pc, INDEX_BITS);
    assign up_idx = INDEX_BITS'(btb_index(update_pc, INDEX_BITS));
    assign up_tag = btb_tag(update_pc, INDEX_BITS);

    always_comb begin
        for (int w = 0; w < BTB_WAYS; w++) begin
            lk_entry[w] = '{valid: valid_q[lk_idx][w], tag: 30'(tag_mem[lk_idx][w]),
                            target: tgt_mem[lk_idx][w]};
            up_entry[w] = '{valid: valid_q[up_idx][w], tag: 30'(tag_mem[up_idx][w]),
                            target: tgt_mem[up_idx][w]};
            up_valid[w]  = up_entry[w].valid;
            up_tag_eq[w] = (up_entry[w].tag == up_tag);
        end
    end

    // Lookup read port: way 0 takes priority on the (impossible) double match.
    always_comb begin
        lk_hit    = 1'b0;
        lk_target = 32'd0;
        if (lk_entry[0].valid && lk_entry[0].tag == lk_tag) begin
            lk_hit    = 1'b1;
            lk_target = lk_entry[0].target;
        end else if (lk_entry[1].valid && lk_entry[1].tag == lk_tag) begin
            lk_hit    = 1'b1;
            lk_target = lk_entry[1].target;
        end
    end

    btb_set_victim u_victim (
        .valid     (up_valid),
        .tag_eq    (up_tag_eq),
        .lru       (lru_q[up_idx]),
        .hit       (up_hit),
        .hit_way   (up_hit_way),
        .alloc_way (up_alloc_way)
    );

    assign up_alloc = update_valid && update_taken && !up_hit;
    assign up_way   = up_hit ? up_hit_way : up_alloc_way;

    // Lookup register stage: stall holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= 32'd0;
            btb_hit    <= 1'b0;
            btb_target <= 32'd0;
        end else if (lookup_en) begin
            fetch_pc_q <= fetch_pc;
            btb_hit    <= lk_hit;
            btb_target <= lk_target;
        end
    end

    // Control state (valid, LRU) is reset; an update in flight during reset is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                lru_q[s] <= 1'b0;
                for (int w = 0; w < BTB_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else if (update_valid && (up_hit || update_taken)) begin
            lru_q[up_idx] <= ~up_way;
            if (up_alloc) begin
                valid_q[up_idx][up_way] <= 1'b1;
            end
        end
    end

    // Tag/target payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && update_valid && update_taken) begin
            tgt_mem[up_idx][up_way] <= update_target;
            if (up_alloc) begin
                tag_mem[up_idx][up_way] <= TAG_BITS'(up_tag);
            end
        end
    end

    assign pred_next_pc = (btb_hit && predicted) ? btb_target : fetch_pc_q + 32'd4;

`ifdef BTB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= 32'd0;
            stat_hits    <= 32'd0;
        end else if (lookup_en) begin
            if (stat_lookups != 32'hFFFF_FFFF) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (lk_hit && stat_hits != 32'hFFFF_FFFF) begin
                stat_hits <= stat_hits + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_btb_next_pc.sv
// Self-checking bench for btb_next_pc: directed scenarios followed by randomized
// traffic, checked against an array-based reference of the BTB.
module tb_btb_next_pc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        lookup_en;
    logic        predicted;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic [31:0] pred_next_pc;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
`endif

    btb_next_pc #(.INDEX_BITS(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_pc      (fetch_pc),
        .lookup_en     (lookup_en),
        .predicted     (predicted),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken),
`ifdef BTB_STATS_EN
        .stat_lookups  (stat_lookups),
        .stat_hits     (stat_hits),
`endif
        .btb_hit       (btb_hit),
        .btb_target    (btb_target),
        .pred_next_pc  (pred_next_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: per set a list of (valid, pc>>6, target) slots and a "replace next" way.
    bit          m_valid [16][2];
    logic [25:0] m_tag   [16][2];
    logic [31:0] m_tgt   [16][2];
    int          m_lru   [16];
    logic [31:0] m_fq;
    bit          m_hit;
    logic [31:0] m_out;
    longint      m_lookups;
    longint      m_hits;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_way(input logic [31:0] pc);
        int s = int'(pc[5:2]);
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == pc[31:6]) return w;
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 16; s++) begin
            m_lru[s] = 0;
            m_valid[s][0] = 0;
            m_valid[s][1] = 0;
        end
        m_fq = 0; m_hit = 0; m_out = 0; m_lookups = 0; m_hits = 0;
    endtask

    task automatic model_edge();
        int w;
        int s;
        if (lookup_en) begin
            w = find_way(fetch_pc);
            m_fq  = fetch_pc;
            m_hit = (w >= 0);
            m_out = (w >= 0) ? m_tgt[int'(fetch_pc[5:2])][w] : 32'd0;
            m_lookups++;
            if (w >= 0) m_hits++;
        end
        if (update_valid) begin
            s = int'(update_pc[5:2]);
            w = find_way(update_pc);
            if (w >= 0) begin
                if (update_taken) m_tgt[s][w] = update_target;
                m_lru[s] = 1 - w;
            end else if (update_taken) begin
                if (!m_valid[s][0]) w = 0;
                else if (!m_valid[s][1]) w = 1;
                else w = m_lru[s];
                m_valid[s][w] = 1;
                m_tag[s][w]   = update_pc[31:6];
                m_tgt[s][w]   = update_target;
                m_lru[s]      = 1 - w;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] npc;
        npc = (m_hit && predicted) ? m_out : m_fq + 32'd4;
        check({tag, ".hit"}, {31'd0, btb_hit}, {31'd0, m_hit});
        check({tag, ".tgt"}, btb_target, m_out);
        check({tag, ".npc"}, pred_next_pc, npc);
`ifdef BTB_STATS_EN
        check({tag, ".lookups"}, stat_lookups, 32'(m_lookups));
        check({tag, ".hits"}, stat_hits, 32'(m_hits));
`endif
    endtask

    task automatic step(input string tag, input logic le, input logic [31:0] fpc, input logic pr,
                        input logic uv, input logic [31:0] upc, input logic [31:0] ut,
                        input logic tk);
        lookup_en = le; fetch_pc = fpc; predicted = pr;
        update_valid = uv; update_pc = upc; update_target = ut; update_taken = tk;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic upd(input string tag, input logic [31:0] upc, input logic [31:0] ut,
                       input logic tk);
        step(tag, 1'b0, 32'd0, 1'b0, 1'b1, upc, ut, tk);
    endtask

    task automatic look(input string tag, input logic [31:0] fpc, input logic pr);
        step(tag, 1'b1, fpc, pr, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        model_clear();
        check_outputs("reset");
        rst = 1'b0;
    endtask

    logic [31:0] held_tgt;

    initial begin
        rst = 1'b0;
        lookup_en = 0; fetch_pc = 0; predicted = 0;
        update_valid = 0; update_pc = 0; update_target = 0; update_taken = 0;
        @(posedge clk); #1;
        do_reset();
        check("reset.npc4", pred_next_pc, 32'h4);

        // Cold lookup misses
        look("cold", 32'h40, 1'b1);
        check("cold.npc", pred_next_pc, 32'h44);

        // Train then hit
        upd("train", 32'h40, 32'h100, 1'b1);
        look("hit_p1", 32'h40, 1'b1);
        check("hit.npc", pred_next_pc, 32'h100);
        predicted = 1'b0; #1;
        check("hit_p0.npc", pred_next_pc, 32'h44);

        // Fill set 0, refresh 0x40, evict 0x440
        upd("fill1", 32'h440, 32'h200, 1'b1);
        upd("refresh", 32'h40, 32'h100, 1'b1);
        upd("evict", 32'h840, 32'h300, 1'b1);
        look("lk40", 32'h40, 1'b1);
        check("lk40.tgt", btb_target, 32'h100);
        look("lk840", 32'h840, 1'b1);
        check("lk840.tgt", btb_target, 32'h300);
        look("lk440", 32'h440, 1'b1);
        check("lk440.hit", {31'd0, btb_hit}, 32'd0);

        // Same-edge update and lookup: read before write
        step("same", 1'b1, 32'h80, 1'b1, 1'b1, 32'h80, 32'h500, 1'b1);
        check("same.hit", {31'd0, btb_hit}, 32'd0);
        look("same_next", 32'h80, 1'b1);
        check("same_next.tgt", btb_target, 32'h500);

        // Not-taken never allocates
        upd("nt", 32'hC0, 32'h600, 1'b0);
        look("nt_lk", 32'hC0, 1'b1);
        check("nt.hit", {31'd0, btb_hit}, 32'd0);

        // Stall after a hit holds outputs
        look("pre_stall", 32'h80, 1'b1);
        held_tgt = btb_target;
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b0, 32'h1234, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
            check("stall.tgt", btb_target, held_tgt);
        end

        // PC wrap
        look("wrap", 32'hFFFF_FFFC, 1'b0);
        check("wrap.npc", pred_next_pc, 32'h0);

        // Reset between update and lookup
        upd("pre_rst", 32'h100, 32'h700, 1'b1);
        do_reset();
        look("post_rst", 32'h100, 1'b1);

        // Reset during an in-flight update discards it
        update_valid = 1; update_pc = 32'h140; update_target = 32'h800; update_taken = 1;
        lookup_en = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        check_outputs("inflight_rst");
        look("inflight_lk", 32'h140, 1'b1);

        // Five lookups, two hits
        do_reset();
        upd("st_u", 32'h24, 32'h900, 1'b1);
        look("st1", 32'h24, 1'b1);
        look("st2", 32'h28, 1'b1);
        look("st3", 32'h24, 1'b0);
        look("st4", 32'h2C, 1'b1);
        look("st5", 32'h30, 1'b1);
`ifdef BTB_STATS_EN
        check("st.lookups5", stat_lookups, 32'd5);
        check("st.hits2", stat_hits, 32'd2);
`endif

        // Randomized traffic over a small PC pool so sets conflict often
        for (int i = 0; i < 800; i++) begin
            logic [31:0] fpc, upc;
            fpc = {24'd0, 2'(($urandom % 4)), 4'($urandom % 4), 2'b00} << 0;
            fpc = (32'($urandom % 4) << 6) | (32'($urandom % 4) << 2);
            upc = (32'($urandom % 4) << 6) | (32'($urandom % 4) << 2);
            if ($urandom % 8 == 0) fpc = fpc | 32'hFFFF_FF00;
            step("rand", ($urandom % 5) != 0, fpc, 1'($urandom),
                 1'($urandom), upc, $urandom, ($urandom % 10) < 7);
            if (i % 250 == 249) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
